// File: rtl/reg_dump_tx.sv
// Register-file dump transmitter: walks x0..x31 through a spare read port and
// sends each value as eight lowercase hex digits plus LF over UART 8N1.
module reg_dump_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter bit HALT_TRIGGER = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] instr,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [31:0] HALT_INSTR = 32'h0000006F;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t state;
    state_t state_next;

    logic [4:0]        reg_idx;
    logic [3:0]        char_idx;
    logic [2:0]        bit_idx;
    logic [BAUD_W-1:0] baud_cnt;
    logic [31:0]       shadow;
    logic              armed;

    logic       is_halt;
    logic       halt_fire;
    logic       trigger;
    logic       baud_end;
    logic       last_char;
    logic       last_reg;
    logic       tx_next;
    logic [3:0] nibble;
    logic [7:0] char_byte;

    // A held halt loop only fires once: arming needs a non-halt instruction first.
    assign is_halt   = (instr == HALT_INSTR);
    assign halt_fire = HALT_TRIGGER && is_halt && armed;
    assign trigger   = start || halt_fire;
    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign last_char = (char_idx == 4'd8);
    assign last_reg  = (reg_idx == 5'd31);
    assign rf_addr   = reg_idx;

    always_comb begin
        nibble = 4'h0;
        case (char_idx[2:0])
            3'd0: nibble = shadow[31:28];
            3'd1: nibble = shadow[27:24];
            3'd2: nibble = shadow[23:20];
            3'd3: nibble = shadow[19:16];
            3'd4: nibble = shadow[15:12];
            3'd5: nibble = shadow[11:8];
            3'd6: nibble = shadow[7:4];
            3'd7: nibble = shadow[3:0];
            default: nibble = 4'h0;
        endcase
    end

    always_comb begin
        char_byte = 8'h0A;
        if (!last_char) begin
            if (nibble < 4'd10)
                char_byte = 8'h30 + {4'h0, nibble};
            else
                char_byte = 8'h57 + {4'h0, nibble};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (trigger) state_next = LOAD;
            LOAD:  state_next = START;
            START: if (baud_end) state_next = DATA;
            DATA:  if (baud_end && bit_idx == 3'd7) state_next = STOP;
            STOP: begin
                if (baud_end) begin
                    if (!last_char)
                        state_next = START;
                    else if (!last_reg)
                        state_next = LOAD;
                    else
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_next = 1'b1;
        busy    = (state != IDLE);
        case (state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = char_byte[bit_idx];
            default: tx_next = 1'b1;
        endcase
    end

    // The line is re-timed through a flop so tx never glitches from inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx   <= 1'b1;
            done <= 1'b0;
        end else begin
            tx   <= tx_next;
            done <= (state == STOP) && baud_end && last_char && last_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_idx  <= 5'd0;
            char_idx <= 4'd0;
            bit_idx  <= 3'd0;
            baud_cnt <= '0;
            shadow   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (trigger)
                        reg_idx <= 5'd0;
                end
                LOAD: begin
                    shadow   <= rf_data;
                    char_idx <= 4'd0;
                    bit_idx  <= 3'd0;
                    baud_cnt <= '0;
                end
                START: begin
                    baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= bit_idx + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (!last_char)
                            char_idx <= char_idx + 1'b1;
                        else if (!last_reg)
                            reg_idx <= reg_idx + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: baud_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            armed <= 1'b1;
        else if (!is_halt)
            armed <= 1'b1;
        else if (state == IDLE && halt_fire)
            armed <= 1'b0;
    end

endmodule

// File: doc/reg_dump_tx.md
# reg_dump_tx

Hardware register-file dump transmitter for the RISC-V processor. On a trigger (explicit `start` pulse, or the core reaching the `jal x0, 0` halt loop) it walks x0..x31 through a spare register-file read port. It serialises each value as 8 lowercase hex ASCII digits plus LF over a UART 8N1 line. Its output has the same one-hex-word-per-line format as the expected-register files, so a host capture can be diffed directly against the expected files on real hardware.

## Interface
- `CLKS_PER_BIT`, 104, clock cycles per UART bit (12 MHz / 115200); legal range ≥ 2
- `HALT_TRIGGER`, 1, 1 = dump automatically on halt instruction, 0 = `start` only
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle dump request
- `instr`  in  32  instruction currently executing (halt detection)
- `rf_addr`  out  5  register-file read address
- `rf_data`  in  32  combinational read data for `rf_addr`, valid same cycle
- `tx`  out  1  UART serial output, idle high
- `busy`  out  1  dump in progress
- `done`  out  1  one-cycle pulse when the final LF stop bit completes

## Operation
- States: IDLE, LOAD, START, DATA, STOP.
- Counters:
  - `reg_idx` 0..31 drives `rf_addr`.
  - `char_idx` 0..8 selects the character.
  - `bit_idx` 0..7.
  - Baud counter 0..CLKS_PER_BIT-1.
- Trigger, evaluated only in IDLE:
  - `start`, or
  - `HALT_TRIGGER` && `instr == 32'h0000006F` && armed.
- Halt arming:
  - Armed is set at reset and whenever `instr != 32'h0000006F`.
  - Armed clears when a halt trigger is taken.
  - A held halt therefore produces exactly one dump.
- IDLE → LOAD on trigger; `reg_idx`=0.
- LOAD:
  - Lasts 1 cycle; `tx`=1.
  - Captures `rf_data` into a 32-bit shadow word.
  - `char_idx`=0, then → START.
- Character encoding:
  - `char_idx` 0..7 selects nibble `shadow[31-4k -: 4]` (MSB first).
  - Nibble 0..9 → 0x30+n; nibble 10..15 → 0x57+n (0x61..0x66).
  - `char_idx` 8 → 0x0A.
- START: `tx`=0 for CLKS_PER_BIT cycles → DATA.
- DATA: 8 bits LSB first, each CLKS_PER_BIT cycles → STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then:
  - `char_idx` < 8 → increment `char_idx`, → START.
  - `char_idx` == 8 and `reg_idx` < 31 → increment `reg_idx`, → LOAD.
  - `char_idx` == 8 and `reg_idx` == 31 → IDLE, pulse `done`.
- x0 is transmitted as read; it is not forced to zero.
- `start` or a halt while `busy` is ignored and not queued.
- `rf_data` changes after LOAD do not affect the line in progress; changes before a later LOAD are picked up.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `rf_addr`=0, state IDLE, armed=1.
- Trigger seen at edge N:
  - `busy`=1 and state LOAD during cycle N+1.
  - `tx` falls at edge N+2.
- Per register: 1 + 9·10·CLKS_PER_BIT cycles.
- Full dump: `busy` is high for 32·(1 + 90·CLKS_PER_BIT) cycles.
- End of dump: `done`=1 for exactly the cycle after the last stop-bit cycle, with `busy`=0 in that cycle.
- Characters within a register are sent back-to-back with no idle gap; a single 1-cycle idle-high gap (LOAD) separates registers.
- `rf_addr` changes only on entry to LOAD and holds through the whole line.
- `tx` is registered, with no combinational path from inputs.
- Reset asserted mid-operation:
  - Immediately (asynchronously) forces `tx`=1, `busy`=0, `done`=0 and state IDLE.
  - The partial byte is abandoned.
  - The next trigger restarts from x0.

## Test plan
- **Reset:** assert `reset` with no clock edges → `tx`=1, `busy`=0, `done`=0, `rf_addr`=0.
- **Single line** (CLKS_PER_BIT=4, register model x0=0, x5=0xDEADBEEF, others 0; pulse `start`) → UART monitor decodes 32 lines.
  - Line 5 bytes are 0x64 0x65 0x61 0x64 0x62 0x65 0x65 0x66 0x0A.
  - Line 0 is "00000000\n".
- **Full-dump length** (CLKS_PER_BIT=4):
  - `busy` is high for exactly 11552 cycles.
  - `done` is high for 1 cycle, immediately after.
  - `tx` falls 2 edges after `start`.
- **Halt trigger:**
  - Hold `instr`=0x0000006F for 30000 cycles → exactly one dump.
  - Drive `instr`=0x00000013 for 1 cycle, then 0x0000006F again → a second dump.
  - With HALT_TRIGGER=0 → no dump.
- **Busy robustness:**
  - `start` pulses during a dump → no effect; byte count stays 288.
  - Changing `rf_data` while line 3 is sending → line 3 matches the value captured at its LOAD.
- **Reset mid-byte:** assert `reset` during DATA of line 7 → `tx`=1 and `busy`=0 in the same timestep; the next `start` produces a complete dump beginning with line x0.
